// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit handshake bundle between the ID/MEX pipeline datapath and
// pipe_hazard_unit. The slave modport is the hazard unit's view; the master
// modport is the pipeline datapath's view. DATA_W/ADDR_W must match the
// parameters of the pipe_hazard_unit instance this bundle is connected to.
interface pipe_hazard_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    // ID-stage operand information
    logic [ADDR_W-1:0] ID_read_addr1;
    logic [ADDR_W-1:0] ID_read_addr2;
    logic              ID_uses_reg2;

    // MEX-stage control and results
    logic              MEX_branch_ctrl;
    logic              MEX_branch_taken;
    logic              MEX_jmp_ctrl;
    logic              MEX_done_ctrl;
    logic              MEX_mem_read;
    logic              MEX_reg_write;
    logic [ADDR_W-1:0] MEX_write_addr;
    logic [DATA_W-1:0] MEX_result;
    logic [DATA_W-1:0] MEX_wb_val;
    logic [DATA_W-1:0] MEX_branch_val;
    logic [DATA_W-1:0] MEX_jmp_val;

    // Hazard-unit responses
    logic              flush;
    logic              stall;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [DATA_W-1:0] fwd_val;
    logic              halted;
    logic [15:0]       stall_count;
    logic [15:0]       flush_count;

    modport slave (
        input  ID_read_addr1, ID_read_addr2, ID_uses_reg2,
        input  MEX_branch_ctrl, MEX_branch_taken, MEX_jmp_ctrl, MEX_done_ctrl,
        input  MEX_mem_read, MEX_reg_write, MEX_write_addr, MEX_result,
        input  MEX_wb_val, MEX_branch_val, MEX_jmp_val,
        output flush, stall, pc_load, pc_target, fwd_sel1, fwd_sel2, fwd_val,
        output halted, stall_count, flush_count
    );

    modport master (
        output ID_read_addr1, ID_read_addr2, ID_uses_reg2,
        output MEX_branch_ctrl, MEX_branch_taken, MEX_jmp_ctrl, MEX_done_ctrl,
        output MEX_mem_read, MEX_reg_write, MEX_write_addr, MEX_result,
        output MEX_wb_val, MEX_branch_val, MEX_jmp_val,
        input  flush, stall, pc_load, pc_target, fwd_sel1, fwd_sel2, fwd_val,
        input  halted, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: control-side companion of the ID->MEX pipeline register.
// Detects redirects (jump / taken branch), program completion and load-use
// hazards from the MEX stage, drives flush/stall/PC redirect, and selects the
// forwarding source for both ID operands using the MEX stage and a one-entry
// writeback history register.
// Detection is Mealy: flush/stall/pc_load rise in the cycle the hazard is seen
// in MEX; the RUN/FLUSH/STALL/HALT machine extends them in later cycles.
// All responses are held at 0 while reset_n is low.
// Optional feature: define HAZARD_PERF_EN to build the saturating 16-bit
// stall/flush performance counters; otherwise both count ports read 0.
module pipe_hazard_unit #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int LOAD_STALL   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    pipe_hazard_unit_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // The shared down-counter only ever holds (cycles - 1), so CNT_MAX-1 must fit.
    localparam int CNT_MAX = (FLUSH_CYCLES > LOAD_STALL) ? FLUSH_CYCLES : LOAD_STALL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);
    localparam bit STALL_MULTI = (LOAD_STALL > 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hist_valid_q;
    logic [ADDR_W-1:0] hist_addr_q;
    logic [DATA_W-1:0] hist_val_q;

    logic              redirect_s;
    logic              load_use_s;
    logic              flush_s;
    logic              stall_s;
    logic              pc_load_s;
    logic [DATA_W-1:0] pc_target_s;
    logic [1:0]        fwd_sel1_s;
    logic [1:0]        fwd_sel2_s;

    // The ALU result itself is steered by the datapath; this unit only selects it.
    logic [DATA_W-1:0] unused_result_s;
    assign unused_result_s = hz.MEX_result;

    // Forwarding source for one operand: MEX stage beats the history entry.
    function automatic logic [1:0] fwd_pick(
        input logic [ADDR_W-1:0] rd_addr,
        input logic              rd_en,
        input logic              mex_wr,
        input logic              mex_load,
        input logic [ADDR_W-1:0] mex_addr,
        input logic              h_valid,
        input logic [ADDR_W-1:0] h_addr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!rd_en) begin
            sel = 2'b00;
        end else if (mex_wr && !mex_load && (mex_addr == rd_addr)) begin
            sel = 2'b01;
        end else if (h_valid && (h_addr == rd_addr)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign redirect_s = hz.MEX_jmp_ctrl | (hz.MEX_branch_ctrl & hz.MEX_branch_taken);
    assign load_use_s = hz.MEX_mem_read & hz.MEX_reg_write &
                        ((hz.MEX_write_addr == hz.ID_read_addr1) |
                         (hz.ID_uses_reg2 & (hz.MEX_write_addr == hz.ID_read_addr2)));

    // Hazard decode: Mealy responses and next state/count for the control FSM.
    always_comb begin
        flush_s     = 1'b0;
        stall_s     = 1'b0;
        pc_load_s   = 1'b0;
        pc_target_s = {DATA_W{1'b0}};
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (!reset_n) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (hz.MEX_done_ctrl) begin
                        flush_s = 1'b1;
                        stall_s = 1'b1;
                        state_d = ST_HALT;
                        cnt_d   = CNT_ZERO;
                    end else if (redirect_s) begin
                        // A redirect also aborts any stall still in progress.
                        flush_s     = 1'b1;
                        pc_load_s   = 1'b1;
                        pc_target_s = hz.MEX_jmp_ctrl ? hz.MEX_jmp_val : hz.MEX_branch_val;
                        if (FLUSH_MULTI) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_ZERO;
                        end
                    end else if (state_q == ST_STALL) begin
                        stall_s = 1'b1;
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            state_d = ST_STALL;
                            cnt_d   = cnt_q - CNT_ONE;
                        end
                    end else if (load_use_s) begin
                        stall_s = 1'b1;
                        if (STALL_MULTI) begin
                            state_d = ST_STALL;
                            cnt_d   = STALL_INIT;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_ZERO;
                        end
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_FLUSH: begin
                    // MEX holds squashed instructions here, so its inputs are ignored.
                    flush_s = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_FLUSH;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                ST_HALT: begin
                    flush_s = 1'b1;
                    stall_s = 1'b1;
                    state_d = ST_HALT;
                    cnt_d   = CNT_ZERO;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Control FSM state and hold-cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writeback history: remember the last register write that was not squashed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_valid_q <= 1'b0;
            hist_addr_q  <= {ADDR_W{1'b0}};
            hist_val_q   <= {DATA_W{1'b0}};
        end else if (flush_s) begin
            hist_valid_q <= 1'b0;
        end else if (hz.MEX_reg_write) begin
            hist_valid_q <= 1'b1;
            hist_addr_q  <= hz.MEX_write_addr;
            hist_val_q   <= hz.MEX_wb_val;
        end else begin
            hist_valid_q <= hist_valid_q;
        end
    end

    // Operand forwarding select; squashed instructions never forward.
    always_comb begin
        fwd_sel1_s = 2'b00;
        fwd_sel2_s = 2'b00;
        if (!reset_n || flush_s) begin
            fwd_sel1_s = 2'b00;
            fwd_sel2_s = 2'b00;
        end else begin
            fwd_sel1_s = fwd_pick(hz.ID_read_addr1, 1'b1, hz.MEX_reg_write, hz.MEX_mem_read,
                                  hz.MEX_write_addr, hist_valid_q, hist_addr_q);
            fwd_sel2_s = fwd_pick(hz.ID_read_addr2, hz.ID_uses_reg2, hz.MEX_reg_write,
                                  hz.MEX_mem_read, hz.MEX_write_addr, hist_valid_q, hist_addr_q);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating performance counters for stall and flush cycles outside HALT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (stall_s && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (flush_s && (state_q != ST_HALT) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'h0001;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
`else
    assign hz.stall_count = 16'h0000;
    assign hz.flush_count = 16'h0000;
`endif

    assign hz.flush     = flush_s;
    assign hz.stall     = stall_s;
    assign hz.pc_load   = pc_load_s;
    assign hz.pc_target = pc_target_s;
    assign hz.fwd_sel1  = fwd_sel1_s;
    assign hz.fwd_sel2  = fwd_sel2_s;
    assign hz.fwd_val   = hist_val_q;
    assign hz.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit. Two instances share one stimulus:
// dut_a (FLUSH_CYCLES=1, LOAD_STALL=2) and dut_b (FLUSH_CYCLES=3, LOAD_STALL=1).
// The stimulus process drives inputs just after a rising edge and queues the
// hand-computed response for one chosen instance; the monitor pops and
// compares on each falling edge.
module tb_pipe_hazard_unit;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] ra1, ra2, wa;
    logic       uses2, br, tk, jmp, done, mrd, rwr;
    logic [7:0] res, wbv, bv, jv;

`ifdef HAZARD_PERF_EN
    localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
    localparam logic [15:0] SAT_EXP = 16'h0000;
`endif

    pipe_hazard_unit_if #(.DATA_W(8), .ADDR_W(3)) ifa ();
    pipe_hazard_unit_if #(.DATA_W(8), .ADDR_W(3)) ifb ();

    assign ifa.ID_read_addr1 = ra1;   assign ifb.ID_read_addr1 = ra1;
    assign ifa.ID_read_addr2 = ra2;   assign ifb.ID_read_addr2 = ra2;
    assign ifa.ID_uses_reg2 = uses2;  assign ifb.ID_uses_reg2 = uses2;
    assign ifa.MEX_branch_ctrl = br;  assign ifb.MEX_branch_ctrl = br;
    assign ifa.MEX_branch_taken = tk; assign ifb.MEX_branch_taken = tk;
    assign ifa.MEX_jmp_ctrl = jmp;    assign ifb.MEX_jmp_ctrl = jmp;
    assign ifa.MEX_done_ctrl = done;  assign ifb.MEX_done_ctrl = done;
    assign ifa.MEX_mem_read = mrd;    assign ifb.MEX_mem_read = mrd;
    assign ifa.MEX_reg_write = rwr;   assign ifb.MEX_reg_write = rwr;
    assign ifa.MEX_write_addr = wa;   assign ifb.MEX_write_addr = wa;
    assign ifa.MEX_result = res;      assign ifb.MEX_result = res;
    assign ifa.MEX_wb_val = wbv;      assign ifb.MEX_wb_val = wbv;
    assign ifa.MEX_branch_val = bv;   assign ifb.MEX_branch_val = bv;
    assign ifa.MEX_jmp_val = jv;      assign ifb.MEX_jmp_val = jv;

    pipe_hazard_unit #(.DATA_W(8), .ADDR_W(3), .FLUSH_CYCLES(1), .LOAD_STALL(2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (ifa.slave)
    );

    pipe_hazard_unit #(.DATA_W(8), .ADDR_W(3), .FLUSH_CYCLES(3), .LOAD_STALL(1)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (ifb.slave)
    );

    typedef struct {
        bit         dut;
        logic       fl, st, pl, hl;
        logic [7:0] pt;
        logic [1:0] s1, s2;
        logic [7:0] fv;
        bit         cc;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string nm, input string fld, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    exp_t  m_e;
    string m_nm;
    logic        o_fl, o_st, o_pl, o_hl;
    logic [7:0]  o_pt, o_fv;
    logic [1:0]  o_s1, o_s2;
    logic [15:0] o_sc, o_fc;

    // Monitor: compare the selected instance against the oldest queued expectation.
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            m_e  = expq.pop_front();
            m_nm = nameq.pop_front();
            if (m_e.dut == 1'b0) begin
                o_fl = ifa.flush; o_st = ifa.stall; o_pl = ifa.pc_load; o_hl = ifa.halted;
                o_pt = ifa.pc_target; o_fv = ifa.fwd_val; o_s1 = ifa.fwd_sel1; o_s2 = ifa.fwd_sel2;
                o_sc = ifa.stall_count; o_fc = ifa.flush_count;
            end else begin
                o_fl = ifb.flush; o_st = ifb.stall; o_pl = ifb.pc_load; o_hl = ifb.halted;
                o_pt = ifb.pc_target; o_fv = ifb.fwd_val; o_s1 = ifb.fwd_sel1; o_s2 = ifb.fwd_sel2;
                o_sc = ifb.stall_count; o_fc = ifb.flush_count;
            end
            check(m_nm, "flush", 16'(o_fl), 16'(m_e.fl));
            check(m_nm, "stall", 16'(o_st), 16'(m_e.st));
            check(m_nm, "pc_load", 16'(o_pl), 16'(m_e.pl));
            check(m_nm, "halted", 16'(o_hl), 16'(m_e.hl));
            check(m_nm, "fwd_sel1", 16'(o_s1), 16'(m_e.s1));
            check(m_nm, "fwd_sel2", 16'(o_s2), 16'(m_e.s2));
            check(m_nm, "fwd_val", 16'(o_fv), 16'(m_e.fv));
            if (m_e.pl) begin
                check(m_nm, "pc_target", 16'(o_pt), 16'(m_e.pt));
            end
            if (m_e.cc) begin
                check(m_nm, "stall_count", o_sc, m_e.sc);
                check(m_nm, "flush_count", o_fc, m_e.fc);
            end
        end
    end

    task automatic expect_o(input string nm, input bit dut, input logic fl, input logic st,
                            input logic pl, input logic [7:0] pt, input logic hl,
                            input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] fv,
                            input bit cc = 1'b0, input logic [15:0] sc = 16'h0000,
                            input logic [15:0] fc = 16'h0000);
        exp_t e;
        e.dut = dut; e.fl = fl; e.st = st; e.pl = pl; e.pt = pt; e.hl = hl;
        e.s1 = s1; e.s2 = s2; e.fv = fv; e.cc = cc; e.sc = sc; e.fc = fc;
        expq.push_back(e);
        nameq.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ra1 = 3'd0; ra2 = 3'd0; wa = 3'd0; uses2 = 1'b0; br = 1'b0; tk = 1'b0;
        jmp = 1'b0; done = 1'b0; mrd = 1'b0; rwr = 1'b0;
        res = 8'h00; wbv = 8'h00; bv = 8'h00; jv = 8'h00;
    endtask

    localparam bit A = 1'b0;
    localparam bit B = 1'b1;

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        expect_o("reset_a", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000, 16'h0000);
        tick();
        expect_o("reset_b", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000, 16'h0000);
        tick();
        reset_n = 1'b1;

        // Redirects on dut_a (single flush cycle)
        jmp = 1'b1; jv = 8'h40;
        expect_o("jump", A, 1, 0, 1, 8'h40, 0, 2'b00, 2'b00, 8'h00); tick();
        idle();
        expect_o("jump_after", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        br = 1'b1; tk = 1'b0; bv = 8'h22;
        expect_o("br_not_taken", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        tk = 1'b1;
        expect_o("br_taken", A, 1, 0, 1, 8'h22, 0, 2'b00, 2'b00, 8'h00); tick();
        jmp = 1'b1; jv = 8'h44;
        expect_o("jmp_over_br", A, 1, 0, 1, 8'h44, 0, 2'b00, 2'b00, 8'h00); tick();
        idle();
        expect_o("idle", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();

        // Load-use on operand 1, LOAD_STALL=2
        mrd = 1'b1; rwr = 1'b1; wa = 3'd3; wbv = 8'h77; ra1 = 3'd3;
        expect_o("ld_use_c1", A, 0, 1, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        mrd = 1'b0; rwr = 1'b0; wa = 3'd0; wbv = 8'h00;
        expect_o("ld_use_c2", A, 0, 1, 0, 8'h00, 0, 2'b10, 2'b00, 8'h77); tick();
        expect_o("ld_use_done", A, 0, 0, 0, 8'h00, 0, 2'b10, 2'b00, 8'h77); tick();

        // ALU forwarding and history
        rwr = 1'b1; wa = 3'd2; res = 8'h5A; wbv = 8'h5A; ra1 = 3'd5; ra2 = 3'd2; uses2 = 1'b1;
        expect_o("fwd2_mex", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b01, 8'h77); tick();
        uses2 = 1'b0;
        expect_o("fwd2_unused", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h5A); tick();
        idle(); ra1 = 3'd2;
        expect_o("fwd1_hist", A, 0, 0, 0, 8'h00, 0, 2'b10, 2'b00, 8'h5A); tick();
        rwr = 1'b1; wa = 3'd2; res = 8'h11; wbv = 8'h11;
        expect_o("fwd1_mex_wins", A, 0, 0, 0, 8'h00, 0, 2'b01, 2'b00, 8'h5A); tick();
        wa = 3'd0; res = 8'h0F; wbv = 8'h0F; ra1 = 3'd0; ra2 = 3'd2; uses2 = 1'b1;
        expect_o("fwd_r0_mex", A, 0, 0, 0, 8'h00, 0, 2'b01, 2'b10, 8'h11); tick();
        idle(); uses2 = 1'b1;
        expect_o("fwd_r0_hist", A, 0, 0, 0, 8'h00, 0, 2'b10, 2'b10, 8'h0F); tick();

        // Load-use on operand 2, aborted by a jump during the stall
        mrd = 1'b1; rwr = 1'b1; wa = 3'd6; wbv = 8'h66; ra1 = 3'd0; ra2 = 3'd6; uses2 = 1'b1;
        expect_o("ld_use2", A, 0, 1, 0, 8'h00, 0, 2'b10, 2'b00, 8'h0F); tick();
        mrd = 1'b0; rwr = 1'b0; wa = 3'd0; wbv = 8'h00; jmp = 1'b1; jv = 8'h10;
        expect_o("stall_abort", A, 1, 0, 1, 8'h10, 0, 2'b00, 2'b00, 8'h66); tick();
        idle();
        expect_o("abort_after", A, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h66); tick();

        // Done together with a taken branch: done wins, then sticky HALT
        done = 1'b1; br = 1'b1; tk = 1'b1; bv = 8'h33;
        expect_o("done_det", A, 1, 1, 0, 8'h00, 0, 2'b00, 2'b00, 8'h66); tick();
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i == 5) begin
                jmp = 1'b1; jv = 8'h55;
            end else if (i == 7) begin
                rwr = 1'b1; wa = 3'd1; wbv = 8'hAA;
            end else begin
                ra1 = 3'd0;
            end
            expect_o("halt_hold", A, 1, 1, 0, 8'h00, 1, 2'b00, 2'b00, 8'h66); tick();
        end

        // dut_b: FLUSH_CYCLES=3
        idle(); reset_n = 1'b0;
        expect_o("reset_b2", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000, 16'h0000);
        tick();
        reset_n = 1'b1;
        br = 1'b1; tk = 1'b1; bv = 8'h50;
        expect_o("fl3_c1", B, 1, 0, 1, 8'h50, 0, 2'b00, 2'b00, 8'h00); tick();
        idle(); jmp = 1'b1; jv = 8'h99;
        expect_o("fl3_c2_ign", B, 1, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        expect_o("fl3_c3_ign", B, 1, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        idle();
        expect_o("fl3_end", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        br = 1'b1; tk = 1'b1; bv = 8'h51;
        expect_o("fl3_again", B, 1, 0, 1, 8'h51, 0, 2'b00, 2'b00, 8'h00); tick();
        idle(); jmp = 1'b1; jv = 8'h99; reset_n = 1'b0;
        expect_o("fl3_reset", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000, 16'h0000);
        tick();
        idle(); reset_n = 1'b1;

        // dut_b: load-use on operand 2, LOAD_STALL=1
        mrd = 1'b1; rwr = 1'b1; wa = 3'd4; wbv = 8'h44; ra2 = 3'd4; uses2 = 1'b1;
        expect_o("ld2_b", B, 0, 1, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00); tick();
        uses2 = 1'b0;
        expect_o("ld2_b_nouse", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h44); tick();

        // Performance counters: long forced stall
        idle(); reset_n = 1'b0;
        expect_o("perf_reset", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000, 16'h0000);
        tick();
        reset_n = 1'b1;
        mrd = 1'b1; rwr = 1'b1; wa = 3'd1; ra1 = 3'd1; wbv = 8'h3C;
        repeat (70000) tick();
        idle();
        expect_o("perf_sat", B, 0, 0, 0, 8'h00, 0, 2'b00, 2'b00, 8'h3C, 1'b1, SAT_EXP, 16'h0000);
        tick();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
